// File: rtl/ulpi_pkg.sv
// Shared types and constants for the ULPI link layer: FSM states, TX CMD
// prefix and the bit layout of PHY-issued RX CMD bytes.
package ulpi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TXCMD,
    ST_DATA,
    ST_STOP,
    ST_TURN,
    ST_RX
  } state_t;

  localparam logic [3:0] TXCMD_TRANSMIT = 4'b0100;

  // RX CMD byte fields as issued by the PHY when dir=1 and nxt=0.
  localparam int RXCMD_LINESTATE_LSB = 0;
  localparam int RXCMD_LINESTATE_W   = 2;
  localparam int RXCMD_VBUS_LSB      = 2;
  localparam int RXCMD_VBUS_W        = 2;
  localparam int RXCMD_RXEVENT_LSB   = 4;
  localparam int RXCMD_RXEVENT_W     = 2;
  localparam int RXCMD_ID_BIT        = 6;
  localparam int RXCMD_ALTINT_BIT    = 7;

  function automatic logic [7:0] txcmd_byte(input logic [3:0] pid);
    return {TXCMD_TRANSMIT, pid};
  endfunction

endpackage

// File: rtl/ulpi_tx_fifo.sv
// TX byte FIFO with a per-packet start pointer so an aborted transmit can be
// replayed from its first byte. Storage is byte + last flag.
module ulpi_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_wr_data,
  input  logic       i_wr_last,
  input  logic       i_wr_valid,
  output logic       o_wr_ready,
  input  logic       i_pop,
  input  logic       i_commit,
  input  logic       i_rewind,
  output logic [7:0] o_head_data,
  output logic       o_head_last
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

  logic [8:0]      r_mem [DEPTH];
  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_rd_ptr;
  logic [ADDR_W:0] r_start_ptr;
  logic            w_full;
  logic            w_wr_fire;

  // Same index with differing wrap bits means the writer lapped the reader.
  assign w_full     = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                      (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign o_wr_ready = !w_full;
  assign w_wr_fire  = i_wr_valid && !w_full;

  // NOTE: storage has no reset; the pointers alone define what is valid, and
  // leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= {i_wr_last, i_wr_data};
    end
  end

  // NOTE: clocked state uses non-blocking assignment so every register sees
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_start_ptr <= '0;
    end else begin
      if (w_wr_fire) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (i_rewind) begin
        r_rd_ptr <= r_start_ptr;
      end else if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      // Commit happens after the last byte is popped, so rd_ptr already
      // points at the next packet's first byte.
      if (i_commit) begin
        r_start_ptr <= r_rd_ptr;
      end
    end
  end

  assign {o_head_last, o_head_data} = r_mem[r_rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/ulpi_link.sv
// ULPI link: transmits buffered packets as TX CMD + data + stp, yields the
// bus to the PHY on dir, and forwards received data / RX CMD bytes.
module ulpi_link #(
  parameter int   FIFO_DEPTH = 16,
  parameter logic RX_CMD_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  input  logic [7:0] ulpi_data_in,
  output logic [7:0] ulpi_data_out,
  output logic       ulpi_data_oe,
  output logic       ulpi_stp,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_abort,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_cmd
);

  import ulpi_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_pkt_cnt;
  logic             w_pending;
  logic             w_pkt_in;
  logic [7:0]       w_head_data;
  logic             w_head_last;
  logic [7:0]       w_drv_data;
  logic             w_drv_oe;
  logic             w_stp;
  logic             w_pop;
  logic             w_commit;
  logic             w_rewind;
  logic             w_abort;
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;
  logic             r_rx_cmd;

  ulpi_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_wr_data  (tx_data),
    .i_wr_last  (tx_last),
    .i_wr_valid (tx_valid),
    .o_wr_ready (tx_ready),
    .i_pop      (w_pop),
    .i_commit   (w_commit),
    .i_rewind   (w_rewind),
    .o_head_data(w_head_data),
    .o_head_last(w_head_last)
  );

  assign w_pkt_in  = tx_valid && tx_ready && tx_last;
  assign w_pending = (r_pkt_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_cnt <= '0;
    end else begin
      unique case ({w_pkt_in, w_commit})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + CNT_ONE;
        2'b01:   r_pkt_cnt <= r_pkt_cnt - CNT_ONE;
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next     = r_state;
    w_drv_data = 8'h00;
    w_drv_oe   = 1'b0;
    w_stp      = 1'b0;
    w_pop      = 1'b0;
    w_commit   = 1'b0;
    w_rewind   = 1'b0;
    w_abort    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (ulpi_dir) begin
          w_next = ST_TURN;
        end else if (w_pending) begin
          w_next = ST_TXCMD;
        end
      end
      ST_TXCMD: begin
        w_drv_data = txcmd_byte(w_head_data[3:0]);
        w_drv_oe   = 1'b1;
        if (ulpi_dir) begin
          w_abort  = 1'b1;
          w_rewind = 1'b1;
          w_next   = ST_TURN;
        end else if (ulpi_nxt) begin
          w_pop  = 1'b1;
          w_next = w_head_last ? ST_STOP : ST_DATA;
        end
      end
      ST_DATA: begin
        w_drv_data = w_head_data;
        w_drv_oe   = 1'b1;
        if (ulpi_dir) begin
          w_abort  = 1'b1;
          w_rewind = 1'b1;
          w_next   = ST_TURN;
        end else if (ulpi_nxt) begin
          w_pop  = 1'b1;
          w_next = w_head_last ? ST_STOP : ST_DATA;
        end
      end
      ST_STOP: begin
        w_stp    = 1'b1;
        w_drv_oe = 1'b1;
        w_commit = 1'b1;
        w_next   = ST_IDLE;
      end
      ST_TURN: begin
        w_next = ulpi_dir ? ST_RX : ST_IDLE;
      end
      ST_RX: begin
        if (!ulpi_dir) begin
          w_next = ST_TURN;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // The PHY may seize the bus mid-byte; release it in the same cycle.
  assign ulpi_data_out = w_drv_data;
  assign ulpi_data_oe  = w_drv_oe && !ulpi_dir;
  assign ulpi_stp      = w_stp;
  assign tx_abort      = w_abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_rx_cmd   <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_cmd   <= 1'b0;
      if ((r_state == ST_RX) && ulpi_dir) begin
        r_rx_data  <= ulpi_data_in;
        r_rx_valid <= ulpi_nxt || RX_CMD_EN;
        r_rx_cmd   <= !ulpi_nxt;
      end
    end
  end

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign rx_cmd   = r_rx_cmd;

endmodule

// File: tb/tb_ulpi_link.sv
// Self-checking bench for ulpi_link: the bench plays the PHY and the user,
// predicting bus traffic from packet contents and RX bytes from the bus rules.
module tb_ulpi_link;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       ulpi_dir;
  logic       ulpi_nxt;
  logic [7:0] ulpi_data_in;
  logic [7:0] ulpi_data_out;
  logic       ulpi_data_oe;
  logic       ulpi_stp;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_abort;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_cmd;

  int checks   = 0;
  int failures = 0;

  // Expected bus traffic, in order: {stp, data_out}.
  logic [8:0] exp_q[$];
  bit         writer_done = 1'b1;

  ulpi_link #(
    .FIFO_DEPTH(DEPTH),
    .RX_CMD_EN (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ulpi_dir     (ulpi_dir),
    .ulpi_nxt     (ulpi_nxt),
    .ulpi_data_in (ulpi_data_in),
    .ulpi_data_out(ulpi_data_out),
    .ulpi_data_oe (ulpi_data_oe),
    .ulpi_stp     (ulpi_stp),
    .tx_data      (tx_data),
    .tx_last      (tx_last),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_abort     (tx_abort),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_cmd       (rx_cmd)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic write_byte(input logic [7:0] d, input logic last);
    int w = 0;
    tx_valid = 1'b1;
    tx_data  = d;
    tx_last  = last;
    while (!tx_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (!tx_ready) begin
      failures++;
      $display("FAIL write_wait: tx_ready=%0b after %0d cycles, required 1", tx_ready, w);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b[$]);
    logic [7:0] first;
    checks++;
    if (b.size() > DEPTH || b.size() == 0) begin
      failures++;
      $display("FAIL pkt_len: length %0d, required 1..%0d", b.size(), DEPTH);
    end
    first = b[0];
    exp_q.push_back({1'b0, 4'b0100, first[3:0]});
    for (int i = 1; i < b.size(); i++) exp_q.push_back({1'b0, b[i]});
    exp_q.push_back({1'b1, 8'h00});
    for (int i = 0; i < b.size(); i++) write_byte(b[i], i == b.size() - 1);
  endtask

  // Acts as the PHY while the link transmits. mode 1 stalls exactly the first
  // cycle of every TX CMD byte, mode 0 throttles nxt at random.
  task automatic drain(input int max_cycles, input int mode);
    int         cyc = 0;
    bit         prev_stp = 1'b0;
    bit         pkt_start = 1'b1;
    bit         stalled = 1'b0;
    logic [8:0] e;
    while ((!writer_done || exp_q.size() != 0) && cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
      if (ulpi_data_oe) begin
        checks++;
        if (prev_stp) begin
          failures++;
          $display("FAIL stp_len: bus still driven after stp cycle, required released");
        end
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_tx: data_out=%h stp=%0b with nothing pending", ulpi_data_out, ulpi_stp);
          ulpi_nxt = 1'b0;
        end else begin
          e = exp_q[0];
          checks++;
          if ({ulpi_stp, ulpi_data_out} !== e) begin
            failures++;
            $display("FAIL tx_byte: stp/data=%0b/%h, required %0b/%h", ulpi_stp, ulpi_data_out, e[8], e[7:0]);
          end
          if (e[8]) begin
            void'(exp_q.pop_front());
            ulpi_nxt  = 1'b0;
            pkt_start = 1'b1;
            stalled   = 1'b0;
          end else begin
            if (mode == 1) begin
              ulpi_nxt = !(pkt_start && !stalled);
              if (pkt_start && !stalled) stalled = 1'b1;
            end else begin
              ulpi_nxt = ($urandom_range(0, 3) != 0);
            end
            if (ulpi_nxt) begin
              void'(exp_q.pop_front());
              pkt_start = 1'b0;
              stalled   = 1'b0;
            end
          end
        end
        prev_stp = ulpi_stp;
      end else begin
        checks++;
        if (ulpi_stp !== 1'b0) begin
          failures++;
          $display("FAIL stp_no_oe: stp=%0b with oe=0, required 0", ulpi_stp);
        end
        ulpi_nxt = 1'b0;
        prev_stp = 1'b0;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d bus bytes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    ulpi_nxt = 1'b0;
  endtask

  task automatic wait_oe(input string tag, output bit ok);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ulpi_data_oe && n < 100);
    ok = ulpi_data_oe;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: oe=0 after %0d cycles, required transmit start", tag, n);
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    int cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (ulpi_data_oe || ulpi_stp) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      failures++;
      $display("FAIL %s: bus active in %0d cycles, required 0", tag, cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ulpi_dir = 1'b0; ulpi_nxt = 1'b0; ulpi_data_in = 8'h00;
    tx_data = 8'h00; tx_last = 1'b0; tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ulpi_data_oe, ulpi_stp, tx_abort, rx_valid, rx_cmd} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctl: oe/stp/abort/rxv/rxc=%b, required 00000",
               {ulpi_data_oe, ulpi_stp, tx_abort, rx_valid, rx_cmd});
    end
    checks++;
    if ({ulpi_data_out, rx_data} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_data: data_out=%h rx_data=%h, required 00/00", ulpi_data_out, rx_data);
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: tx_ready=%0b, required 1", tx_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tx_three();
    logic [7:0] q[$];
    q = '{8'h03, 8'hAA, 8'h55};
    send_pkt(q);
    drain(100, 1);
    idle_check("tx3_idle_after", 8);
  endtask

  task automatic test_single_byte();
    logic [7:0] q[$];
    q = '{8'h02};
    send_pkt(q);
    drain(100, 1);
    idle_check("single_idle_after", 8);
  endtask

  task automatic test_abort();
    logic [7:0] q[$];
    bit ok;
    q = '{8'h05, 8'h11, 8'h22, 8'h33};
    send_pkt(q);
    wait_oe("abort_start", ok);
    if (!ok) begin
      exp_q.delete();
      return;
    end
    checks++;
    if (ulpi_data_out !== 8'h45) begin
      failures++;
      $display("FAIL abort_txcmd: data_out=%h, required 45", ulpi_data_out);
    end
    ulpi_nxt = 1'b1;
    @(negedge clk);
    ulpi_nxt = 1'b1;
    @(negedge clk);
    checks++;
    if ({ulpi_data_oe, ulpi_data_out} !== {1'b1, 8'h22}) begin
      failures++;
      $display("FAIL abort_byte2: oe/data=%0b/%h, required 1/22", ulpi_data_oe, ulpi_data_out);
    end
    ulpi_dir = 1'b1;
    ulpi_nxt = 1'b0;
    #1;
    checks++;
    if ({ulpi_data_oe, tx_abort} !== 2'b01) begin
      failures++;
      $display("FAIL abort_same_cycle: oe/abort=%0b/%0b, required 0/1", ulpi_data_oe, tx_abort);
    end
    @(negedge clk);
    checks++;
    if ({ulpi_data_oe, tx_abort} !== 2'b00) begin
      failures++;
      $display("FAIL abort_pulse: oe/abort=%0b/%0b in turnaround, required 0/0", ulpi_data_oe, tx_abort);
    end
    @(negedge clk);
    ulpi_nxt     = 1'b1;
    ulpi_data_in = 8'h77;
    @(negedge clk);
    checks++;
    if ({rx_valid, rx_cmd, rx_data} !== {2'b10, 8'h77}) begin
      failures++;
      $display("FAIL abort_rx: valid/cmd/data=%0b/%0b/%h, required 1/0/77", rx_valid, rx_cmd, rx_data);
    end
    ulpi_dir = 1'b0;
    ulpi_nxt = 1'b0;
    ulpi_data_in = 8'h00;
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_rx_turn: rx_valid=%0b in turnaround, required 0", rx_valid);
    end
    drain(200, 0);
    idle_check("abort_idle_after", 8);
  endtask

  task automatic test_rx();
    logic [7:0] pd[4];
    bit         pn[4];
    logic [9:0] expv;
    pd = '{8'h1C, 8'h01, 8'h02, 8'h1D};
    pn = '{1'b0, 1'b1, 1'b1, 1'b0};
    ulpi_dir = 1'b1;
    ulpi_nxt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL rx_turn: rx_valid=%0b before first RX cycle, required 0", rx_valid);
    end
    for (int i = 0; i < 24; i++) begin
      if (i < 4) begin
        ulpi_nxt     = pn[i];
        ulpi_data_in = pd[i];
      end else begin
        ulpi_nxt     = $urandom_range(0, 1);
        ulpi_data_in = 8'($urandom);
      end
      // Data bytes are qualified by nxt; everything else is an RX CMD.
      expv = ulpi_nxt ? {2'b10, ulpi_data_in} : {2'b11, ulpi_data_in};
      @(negedge clk);
      checks++;
      if ({rx_valid, rx_cmd, rx_data} !== expv) begin
        failures++;
        $display("FAIL rx_byte[%0d]: valid/cmd/data=%0b/%0b/%h, required %0b/%0b/%h",
                 i, rx_valid, rx_cmd, rx_data, expv[9], expv[8], expv[7:0]);
      end
    end
    ulpi_dir = 1'b0;
    ulpi_nxt = 1'b0;
    ulpi_data_in = 8'h00;
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL rx_dir_fall: rx_valid=%0b in turnaround, required 0", rx_valid);
    end
    idle_check("rx_idle_after", 4);
  endtask

  task automatic test_full();
    logic [7:0] q[$];
    bit ok;
    ulpi_dir = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int p = 0; p < DEPTH / 4; p++) begin
      q.delete();
      for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
      send_pkt(q);
    end
    checks++;
    if (tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready: tx_ready=%0b after %0d writes, required 0", tx_ready, DEPTH);
    end
    tx_valid = 1'b1;
    tx_data  = 8'hEE;
    tx_last  = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_refuse: tx_ready=%0b with write pending on full, required 0", tx_ready);
    end
    ulpi_dir = 1'b0;
    wait_oe("full_start", ok);
    if (!ok) begin
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      exp_q.delete();
      return;
    end
    checks++;
    if ({tx_ready, ulpi_data_out} !== {1'b0, exp_q[0][7:0]}) begin
      failures++;
      $display("FAIL full_txcmd: ready/data=%0b/%h, required 0/%h", tx_ready, ulpi_data_out, exp_q[0][7:0]);
    end
    ulpi_nxt = 1'b1;
    void'(exp_q.pop_front());
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_pop_ready: tx_ready=%0b after one pop, required 1", tx_ready);
    end
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    ulpi_nxt = 1'b0;
    drain(600, 0);
    idle_check("full_no_extra_pkt", 10);
  endtask

  task automatic test_random();
    writer_done = 1'b0;
    fork
      begin
        logic [7:0] q[$];
        for (int p = 0; p < 12; p++) begin
          q.delete();
          for (int i = 0; i < $urandom_range(1, 8); i++) q.push_back(8'($urandom));
          send_pkt(q);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        writer_done = 1'b1;
      end
      drain(3000, 0);
    join
    idle_check("random_idle_after", 8);
  endtask

  task automatic test_reset_mid();
    logic [7:0] q[$];
    logic [7:0] b2;
    bit ok;
    q = '{8'h07, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    send_pkt(q);
    wait_oe("rstmid_start", ok);
    if (ok) begin
      ulpi_nxt = 1'b1;
      @(negedge clk);
      ulpi_nxt = 1'b1;
      @(negedge clk);
      b2 = exp_q[2][7:0];
      checks++;
      if ({ulpi_data_oe, ulpi_data_out} !== {1'b1, b2}) begin
        failures++;
        $display("FAIL rstmid_data: oe/data=%0b/%h, required 1/%h", ulpi_data_oe, ulpi_data_out, b2);
      end
      ulpi_nxt = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if ({ulpi_data_oe, ulpi_stp, tx_abort, rx_valid, rx_cmd, ulpi_data_out} !== 13'h0) begin
        failures++;
        $display("FAIL rstmid_outputs: oe/stp/abort/rxv/rxc=%b data=%h, required 0",
                 {ulpi_data_oe, ulpi_stp, tx_abort, rx_valid, rx_cmd}, ulpi_data_out);
      end
      @(negedge clk);
      rst = 1'b0;
    end
    exp_q.delete();
    idle_check("rstmid_no_restart", 12);
    checks++;
    if (tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_ready: tx_ready=%0b after reset, required 1", tx_ready);
    end
  endtask

  initial begin
    test_reset();
    test_tx_three();
    test_single_byte();
    test_abort();
    test_rx();
    test_full();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
